// File: rtl/program_memory_if.sv
// CPU memory port, program loader handshake and run sequencing for program_memory.
// With PROGRAM_MEMORY_CHECKSUM_EN defined, the interface also carries load_checksum.
interface program_memory_if #(
    parameter int WORD_SIZE     = 16,
    parameter int MEM_ADDR_SIZE = 8
);
    logic                     load_start;
    logic                     load_valid;
    logic [7:0]               load_data;
    logic                     load_last;
    logic                     load_ready;
    logic                     load_error;
    logic [MEM_ADDR_SIZE-1:0] mem_address;
    logic                     mem_read;
    logic                     mem_write;
    logic [WORD_SIZE-1:0]     mem_write_data;
    logic [WORD_SIZE-1:0]     mem_read_data;
    logic                     execute;
    logic                     halted;
    logic                     busy;
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
    logic [7:0]               load_checksum;

    modport master (
        output load_start, load_valid, load_data, load_last,
        output mem_address, mem_read, mem_write, mem_write_data, halted,
        input  load_ready, load_error, mem_read_data, execute, busy, load_checksum
    );
    modport slave (
        input  load_start, load_valid, load_data, load_last,
        input  mem_address, mem_read, mem_write, mem_write_data, halted,
        output load_ready, load_error, mem_read_data, execute, busy, load_checksum
    );
`else
    modport master (
        output load_start, load_valid, load_data, load_last,
        output mem_address, mem_read, mem_write, mem_write_data, halted,
        input  load_ready, load_error, mem_read_data, execute, busy
    );
    modport slave (
        input  load_start, load_valid, load_data, load_last,
        input  mem_address, mem_read, mem_write, mem_write_data, halted,
        output load_ready, load_error, mem_read_data, execute, busy
    );
`endif
endinterface

// File: rtl/program_memory.sv
// Unified instruction/data memory with a byte-serial program loader and run sequencer.
// Optional load checksum output enabled by defining PROGRAM_MEMORY_CHECKSUM_EN.
module program_memory #(
    parameter int WORD_SIZE     = 16,
    parameter int MEM_ADDR_SIZE = 8,
    parameter int MEM_DEPTH     = 256
) (
    input  logic              clock,
    input  logic              reset,
    program_memory_if.slave   bus
);
    localparam int BYTES = WORD_SIZE / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE} state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         byte_cnt_q, byte_cnt_d;
    logic [MEM_ADDR_SIZE:0]   load_addr_q, load_addr_d;
    logic [WORD_SIZE-1:0]     word_q, word_d;
    logic                     load_error_q, load_error_d;
    logic [7:0]               checksum_q, checksum_d;

    logic [WORD_SIZE-1:0]     mem [MEM_DEPTH];
    logic                     mem_we;
    logic [MEM_ADDR_SIZE-1:0] mem_waddr;
    logic [WORD_SIZE-1:0]     mem_wdata;

    logic                     accept;
    logic                     word_done;
    logic                     overflow;
    logic [WORD_SIZE-1:0]     assembled;

    // Each byte is ORed into its slot of a zeroed word, so a short final word is zero-padded for free.
    always_comb begin
        accept    = (state_q == LOAD) && bus.load_valid;
        word_done = bus.load_last || (byte_cnt_q == CNT_W'(BYTES - 1));
        overflow  = (load_addr_q >= (MEM_ADDR_SIZE + 1)'(MEM_DEPTH));
        assembled = word_q | (WORD_SIZE'(bus.load_data) << (8 * (BYTES - 1 - int'(byte_cnt_q))));
    end

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        load_addr_d  = load_addr_q;
        word_d       = word_q;
        load_error_d = load_error_q;
        checksum_d   = checksum_q;
        mem_we       = 1'b0;
        mem_waddr    = bus.mem_address;
        mem_wdata    = bus.mem_write_data;

        case (state_q)
            IDLE, DONE: begin
                if (bus.load_start) begin
                    state_d      = LOAD;
                    byte_cnt_d   = '0;
                    load_addr_d  = '0;
                    word_d       = '0;
                    load_error_d = 1'b0;
                    checksum_d   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    checksum_d = checksum_q + bus.load_data;
                    if (word_done) begin
                        byte_cnt_d = '0;
                        word_d     = '0;
                        if (overflow) begin
                            load_error_d = 1'b1;
                        end else begin
                            mem_we      = 1'b1;
                            mem_waddr   = load_addr_q[MEM_ADDR_SIZE-1:0];
                            mem_wdata   = assembled;
                            load_addr_d = load_addr_q + (MEM_ADDR_SIZE + 1)'(1);
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        word_d     = assembled;
                    end
                    if (bus.load_last) begin
                        state_d = load_error_d ? IDLE : START;
                    end
                end
            end
            START: state_d = RUN;
            RUN: begin
                mem_we = bus.mem_write;
                if (bus.halted) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            byte_cnt_q   <= '0;
            load_addr_q  <= '0;
            word_q       <= '0;
            load_error_q <= 1'b0;
            checksum_q   <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            load_addr_q  <= load_addr_d;
            word_q       <= word_d;
            load_error_q <= load_error_d;
            checksum_q   <= checksum_d;
        end
    end

    // NOTE: the array has no reset so it maps onto plain RAM; only the write enable is gated by reset.
    always_ff @(posedge clock) begin
        if (reset && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.load_ready    = (state_q == LOAD);
    assign bus.load_error    = load_error_q;
    assign bus.execute       = (state_q == START);
    assign bus.busy          = (state_q != IDLE) && (state_q != DONE);
    assign bus.mem_read_data = (((state_q == RUN) || (state_q == DONE)) && bus.mem_read)
                               ? mem[bus.mem_address] : '0;

`ifdef PROGRAM_MEMORY_CHECKSUM_EN
    assign bus.load_checksum = checksum_q;
`endif
endmodule

// File: tb/tb_program_memory.sv
// Self-checking bench for program_memory: loader, run sequencing and CPU-port accesses.
// Loaded words go to a scoreboard and are read back through the CPU port once in RUN.
module tb_program_memory;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    program_memory_if #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8)) bus ();

    program_memory #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8), .MEM_DEPTH(256)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } sb_t;

    typedef struct {
        logic [7:0]  addr;
        logic        rd;
        logic        wr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    sb_t        sb_q[$];
    vec_t       vecs[7];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_cks  = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        exp_cks = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        bus.load_valid = 1'b1;
        bus.load_data  = b;
        bus.load_last  = last;
        while (!bus.load_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) check("ready_timeout", 32'(bus.load_ready), 32'(1));
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        exp_cks = exp_cks + b;
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [15:0] d);
        sb_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Called right after the edge that accepted load_last of a good program.
    task automatic check_start(input string tag);
        check({tag, "_execute_hi"}, 32'(bus.execute), 32'(1));
        check({tag, "_busy_start"}, 32'(bus.busy), 32'(1));
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
        check({tag, "_checksum"}, 32'(bus.load_checksum), 32'(exp_cks));
`endif
        tick();
        check({tag, "_execute_lo"}, 32'(bus.execute), 32'(0));
        check({tag, "_busy_run"}, 32'(bus.busy), 32'(1));
    endtask

    task automatic drain();
        while (sb_q.size() > 0) begin
            sb_t e = sb_q.pop_front();
            bus.mem_address = e.addr;
            bus.mem_read    = 1'b1;
            #1;
            check($sformatf("sb_rd_a%0d", e.addr), 32'(bus.mem_read_data), 32'(e.data));
        end
        bus.mem_read = 1'b0;
    endtask

    task automatic halt();
        bus.halted = 1'b1;
        tick();
        bus.halted = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{addr: 8'd1, rd: 1'b1, wr: 1'b0, wdata: 16'h0000, exp: 16'h5678};
        vecs[1] = '{addr: 8'd1, rd: 1'b1, wr: 1'b1, wdata: 16'hBEEF, exp: 16'h5678};
        vecs[2] = '{addr: 8'd1, rd: 1'b1, wr: 1'b0, wdata: 16'h0000, exp: 16'hBEEF};
        vecs[3] = '{addr: 8'd0, rd: 1'b0, wr: 1'b1, wdata: 16'hCAFE, exp: 16'h0000};
        vecs[4] = '{addr: 8'd0, rd: 1'b1, wr: 1'b0, wdata: 16'h0000, exp: 16'hCAFE};
        vecs[5] = '{addr: 8'd2, rd: 1'b0, wr: 1'b1, wdata: 16'h0F0F, exp: 16'h0000};
        vecs[6] = '{addr: 8'd2, rd: 1'b1, wr: 1'b0, wdata: 16'h0000, exp: 16'h0F0F};

        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        bus.load_last  = 1'b0;
        bus.mem_address = 8'h00;
        bus.mem_read    = 1'b1;
        bus.mem_write   = 1'b0;
        bus.mem_write_data = 16'h0000;
        bus.halted      = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_ready", 32'(bus.load_ready), 32'(0));
        check("rst_error", 32'(bus.load_error), 32'(0));
        check("rst_execute", 32'(bus.execute), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_rdata", 32'(bus.mem_read_data), 32'(0));
        bus.mem_read = 1'b0;
        rst_n = 1'b1;
        tick();

        // Four-byte program, two full words
        start_load();
        check("load_ready", 32'(bus.load_ready), 32'(1));
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        send_byte(8'h78, 1'b1);
        push_exp(8'd0, 16'h1234);
        push_exp(8'd1, 16'h5678);
        check_start("p1");
        drain();

        // CPU access vectors in RUN
        for (int i = 0; i < 7; i++) begin
            bus.mem_address    = vecs[i].addr;
            bus.mem_read       = vecs[i].rd;
            bus.mem_write      = vecs[i].wr;
            bus.mem_write_data = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_rdata", i), 32'(bus.mem_read_data), 32'(vecs[i].exp));
            @(posedge clk);
            #1;
            bus.mem_write = 1'b0;
            bus.mem_read  = 1'b0;
        end

        // Halt -> DONE, writes ignored, reads still served
        halt();
        check("done_busy", 32'(bus.busy), 32'(0));
        check("done_execute", 32'(bus.execute), 32'(0));
        bus.mem_address    = 8'd0;
        bus.mem_write      = 1'b1;
        bus.mem_write_data = 16'h1111;
        tick();
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b1;
        #1;
        check("done_write_ignored", 32'(bus.mem_read_data), 32'(16'hCAFE));
        bus.mem_read = 1'b0;

        // Reload from DONE: three bytes with a valid gap mid-word, last word zero-padded
        start_load();
        send_byte(8'hAB, 1'b0);
        bus.mem_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("gap%0d_ready", i), 32'(bus.load_ready), 32'(1));
            check($sformatf("gap%0d_rdata", i), 32'(bus.mem_read_data), 32'(0));
        end
        bus.mem_read = 1'b0;
        send_byte(8'hCD, 1'b0);
        send_byte(8'hEF, 1'b1);
        push_exp(8'd0, 16'hABCD);
        push_exp(8'd1, 16'hEF00);
        push_exp(8'd2, 16'h0F0F);
        check_start("p2");
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
        check("p2_checksum_const", 32'(bus.load_checksum), 32'(8'h67));
`endif
        drain();
        halt();

        // Reset mid-load discards the partial word
        start_load();
        send_byte(8'h99, 1'b0);
        rst_n = 1'b0;
        tick();
        check("mrst_ready", 32'(bus.load_ready), 32'(0));
        check("mrst_busy", 32'(bus.busy), 32'(0));
        check("mrst_execute", 32'(bus.execute), 32'(0));
        check("mrst_error", 32'(bus.load_error), 32'(0));
        rst_n = 1'b1;
        tick();
        start_load();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        push_exp(8'd0, 16'h0102);
        check_start("p3");
        drain();
        halt();

        // Overflow: 257 words offered to a 256-word array
        start_load();
        for (int i = 0; i < 257; i++) begin
            send_byte(8'(i), 1'b0);
            send_byte(~8'(i), (i == 256));
            if (i == 255) begin
                check("ovf_full_no_error", 32'(bus.load_error), 32'(0));
                check("ovf_full_busy", 32'(bus.busy), 32'(1));
            end
        end
        check("ovf_error", 32'(bus.load_error), 32'(1));
        check("ovf_busy", 32'(bus.busy), 32'(0));
        check("ovf_no_execute", 32'(bus.execute), 32'(0));
        check("ovf_ready", 32'(bus.load_ready), 32'(0));
`ifdef PROGRAM_MEMORY_CHECKSUM_EN
        check("ovf_checksum", 32'(bus.load_checksum), 32'(8'hFF));
`endif
        tick();
        check("ovf_no_execute2", 32'(bus.execute), 32'(0));
        check("ovf_error_sticky", 32'(bus.load_error), 32'(1));
        push_exp(8'd255, 16'hFF00);
        push_exp(8'd128, 16'h807F);
        push_exp(8'd1, 16'h01FE);

        // Short reload from IDLE clears the error and exposes the overflow load's words
        start_load();
        check("reload_error_clr", 32'(bus.load_error), 32'(0));
        send_byte(8'hA5, 1'b0);
        send_byte(8'h5A, 1'b1);
        push_exp(8'd0, 16'hA55A);
        check_start("p4");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
